// File: rtl/el2_pkg.sv
// Shared constants and types for the TLU hardware performance monitor.
// CSR address bases and the packed mhpmevent payload layout.
package el2_pkg;

  localparam int unsigned HPM_FIRST    = 3;
  localparam int unsigned HPM_SEL_W    = 10;
  localparam int unsigned HPM_EV_SPACE = 1 << HPM_SEL_W;

  localparam logic [11:0] HPM_CNT_LO_BASE = 12'hB00;
  localparam logic [11:0] HPM_CNT_HI_BASE = 12'hB80;
  localparam logic [11:0] HPM_EVT_BASE    = 12'h320;
  localparam logic [11:0] MCOUNTINHIBIT   = 12'h320;

  typedef struct packed {
    logic                 of;
    logic                 ovfen;
    logic [HPM_SEL_W-1:0] sel;
  } hpm_evt_t;

  // CSR view of an event register: OF at 31, OVFEN at 30, sel in the low bits.
  function automatic logic [31:0] hpm_evt_pack(input hpm_evt_t e);
    return {e.of, e.ovfen, 20'b0, e.sel};
  endfunction

endpackage

// File: rtl/el2_dec_tlu_hpm_cnt.sv
// One hpm counter with its event-select register and overflow flag.
// OF/OVFEN exist only when RV_HPM_OVF_INT_EN is defined.
module el2_dec_tlu_hpm_cnt
  import el2_pkg::*;
#(
  parameter int unsigned NUM_EV = 64,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EV-1:0] ev_i,
  input  logic              inhibit_i,
  input  logic              freeze_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic              wr_evt_i,
  input  logic [31:0]       wdata_i,
  output logic [CNT_W-1:0]  cnt_o,
  output hpm_evt_t          evt_o
);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [HPM_SEL_W-1:0]    sel_q, sel_d;
  logic [HPM_EV_SPACE-1:0] ev_pad;
  logic                    count_en;

  // Zero padding makes every sel >= NUM_EV select a constant-0 event.
  assign ev_pad   = HPM_EV_SPACE'(ev_i);
  assign count_en = (sel_q != '0) & ev_pad[sel_q] & ~inhibit_i & ~freeze_i;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
    end else if (count_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (wr_evt_i) sel_d = wdata_i[HPM_SEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign cnt_o = cnt_q;

`ifdef RV_HPM_OVF_INT_EN
  logic of_q, of_d, ovfen_q, ovfen_d, hw_ovf;

  // Wrap only happens on a real increment; a CSR write suppresses it.
  assign hw_ovf = count_en & ~wr_lo_i & ~wr_hi_i & (&cnt_q);

  // Hardware set of OF dominates a same-cycle software clear.
  always_comb begin
    of_d    = of_q | hw_ovf;
    ovfen_d = ovfen_q;
    if (wr_evt_i) begin
      of_d    = wdata_i[31] | hw_ovf;
      ovfen_d = wdata_i[30];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      of_q    <= 1'b0;
      ovfen_q <= 1'b0;
    end else begin
      of_q    <= of_d;
      ovfen_q <= ovfen_d;
    end
  end

  assign evt_o = '{of: of_q, ovfen: ovfen_q, sel: sel_q};
`else
  assign evt_o = '{of: 1'b0, ovfen: 1'b0, sel: sel_q};
`endif

endmodule

// File: rtl/el2_dec_tlu_hpm.sv
// Hardware performance monitor CSR block: mhpmcounterN/Nh, mhpmeventN, mcountinhibit.
// Overflow interrupt support is built only when RV_HPM_OVF_INT_EN is defined.
module el2_dec_tlu_hpm
  import el2_pkg::*;
#(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned NUM_EV  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EV-1:0] ev_in,
  input  logic              halt_freeze,
  input  logic              csr_wen,
  input  logic [11:0]       csr_waddr,
  input  logic [31:0]       csr_wdata,
  input  logic              csr_ren,
  input  logic [11:0]       csr_raddr,
  output logic [31:0]       csr_rdata,
  output logic              csr_rvalid,
  output logic              csr_rhit,
  output logic              hpm_ovf_int
);

  localparam int unsigned INH_HI = HPM_FIRST + NUM_CNT - 1;

  logic [CNT_W-1:0]   cnt [NUM_CNT];
  hpm_evt_t           evt [NUM_CNT];
  logic [NUM_CNT-1:0] inh_q, inh_d;
  logic [31:0]        rdata_q, rdata_d, rd_data;
  logic               rvalid_q, rvalid_d, rhit_q, rhit_d, rd_hit;

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    localparam logic [11:0] IDX = 12'(HPM_FIRST + gi);

    el2_dec_tlu_hpm_cnt #(
      .NUM_EV (NUM_EV),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .ev_i      (ev_in),
      .inhibit_i (inh_q[gi]),
      .freeze_i  (halt_freeze),
      .wr_lo_i   (csr_wen && (csr_waddr == (HPM_CNT_LO_BASE + IDX))),
      .wr_hi_i   (csr_wen && (csr_waddr == (HPM_CNT_HI_BASE + IDX))),
      .wr_evt_i  (csr_wen && (csr_waddr == (HPM_EVT_BASE + IDX))),
      .wdata_i   (csr_wdata),
      .cnt_o     (cnt[gi]),
      .evt_o     (evt[gi])
    );
  end

  always_comb begin
    inh_d = inh_q;
    if (csr_wen && (csr_waddr == MCOUNTINHIBIT)) inh_d = csr_wdata[INH_HI:HPM_FIRST];
  end

  // Read mux sees pre-write state; the registered result lands next cycle.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (csr_raddr == MCOUNTINHIBIT) begin
      rd_hit  = 1'b1;
      rd_data = 32'(inh_q) << HPM_FIRST;
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_raddr == (HPM_CNT_LO_BASE + 12'(HPM_FIRST + i))) begin
        rd_hit  = 1'b1;
        rd_data = cnt[i][31:0];
      end
      if (csr_raddr == (HPM_CNT_HI_BASE + 12'(HPM_FIRST + i))) begin
        rd_hit  = 1'b1;
        rd_data = 32'(cnt[i][CNT_W-1:32]);
      end
      if (csr_raddr == (HPM_EVT_BASE + 12'(HPM_FIRST + i))) begin
        rd_hit  = 1'b1;
        rd_data = hpm_evt_pack(evt[i]);
      end
    end
  end

  always_comb begin
    rvalid_d = csr_ren;
    rhit_d   = csr_ren & rd_hit;
    rdata_d  = csr_ren ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_q    <= '1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
    end else begin
      inh_q    <= inh_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rhit_q   <= rhit_d;
    end
  end

  assign csr_rdata  = rdata_q;
  assign csr_rvalid = rvalid_q;
  assign csr_rhit   = rhit_q;

`ifdef RV_HPM_OVF_INT_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) ovf_d = ovf_d | (evt[i].of & evt[i].ovfen);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign hpm_ovf_int = ovf_q;
`else
  assign hpm_ovf_int = 1'b0;
`endif

endmodule

// File: tb/tb_el2_dec_tlu_hpm.sv
// Scoreboard bench for el2_dec_tlu_hpm; expectations follow RV_HPM_OVF_INT_EN when defined.
module tb_el2_dec_tlu_hpm;

  localparam int unsigned NUM_CNT = 4;
  localparam int unsigned CNT_W   = 64;
  localparam int unsigned NUM_EV  = 64;

`ifdef RV_HPM_OVF_INT_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_EV-1:0] ev_in = '0;
  logic              halt_freeze = 1'b0;
  logic              csr_wen = 1'b0;
  logic [11:0]       csr_waddr = '0;
  logic [31:0]       csr_wdata = '0;
  logic              csr_ren = 1'b0;
  logic [11:0]       csr_raddr = '0;
  logic [31:0]       csr_rdata;
  logic              csr_rvalid;
  logic              csr_rhit;
  logic              hpm_ovf_int;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  el2_dec_tlu_hpm #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .NUM_EV  (NUM_EV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_in       (ev_in),
    .halt_freeze (halt_freeze),
    .csr_wen     (csr_wen),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .csr_ren     (csr_ren),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_rvalid  (csr_rvalid),
    .csr_rhit    (csr_rhit),
    .hpm_ovf_int (hpm_ovf_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output side of the scoreboard: every rvalid must match the oldest pending read.
  always @(negedge clk) begin
    if (csr_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'(csr_rvalid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_latency", 64'(cyc), 64'(e.cyc));
        chk("rd_data", 64'(csr_rdata), 64'(e.data));
        chk("rd_hit", 64'(csr_rhit), 64'(e.hit));
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic wen, input logic [11:0] wa, input logic [31:0] wd,
                      input logic ren, input logic [11:0] ra, input logic [31:0] ed,
                      input logic eh, input logic [NUM_EV-1:0] ev);
    csr_wen   = wen;
    csr_waddr = wa;
    csr_wdata = wd;
    csr_ren   = ren;
    csr_raddr = ra;
    ev_in     = ev;
    if (ren) sb.push_back('{data: ed, hit: eh, cyc: cyc + 1});
    @(posedge clk);
    #1;
    csr_wen = 1'b0;
    csr_ren = 1'b0;
    ev_in   = '0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 12'h0, 32'h0, 1'b0, '0);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic eh);
    step(1'b0, 12'h0, 32'h0, 1'b1, a, ed, eh, '0);
  endtask

  task automatic events(input logic [NUM_EV-1:0] ev, input int n);
    ev_in = ev;
    repeat (n) @(posedge clk);
    #1;
    ev_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_EV-1:0] ev5, ev7, ev63;
    ev5  = NUM_EV'(1) << 5;
    ev7  = NUM_EV'(1) << 7;
    ev63 = NUM_EV'(1) << 63;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rdata", 64'(csr_rdata), 64'd0);
    chk("rst_rvalid", 64'(csr_rvalid), 64'd0);
    chk("rst_rhit", 64'(csr_rhit), 64'd0);
    chk("rst_int", 64'(hpm_ovf_int), 64'd0);
    rd(12'h320, 32'h78, 1'b1);
    rd(12'hB03, 32'h0, 1'b1);
    rd(12'h323, 32'h0, 1'b1);

    // Basic counting on counter 3, event 5.
    wr(12'h320, 32'h70);
    rd(12'h320, 32'h70, 1'b1);
    wr(12'h323, 32'd5);
    events(ev5, 10);
    rd(12'hB03, 32'd10, 1'b1);
    rd(12'hB83, 32'd0, 1'b1);
    rd(12'hB04, 32'd0, 1'b1);
    rd(12'hB06, 32'd0, 1'b1);

    // Freeze, out-of-range select and select 0 must not count.
    halt_freeze = 1'b1;
    events(ev5, 5);
    halt_freeze = 1'b0;
    rd(12'hB03, 32'd10, 1'b1);
    wr(12'h323, 32'(NUM_EV));
    events('1, 5);
    rd(12'hB03, 32'd10, 1'b1);
    wr(12'h323, 32'd0);
    events('1, 3);
    rd(12'hB03, 32'd10, 1'b1);
    wr(12'h323, 32'(NUM_EV - 1));
    events(ev63, 3);
    rd(12'hB03, 32'd13, 1'b1);
    rd(12'h323, 32'h3F, 1'b1);

    // Write beats a same-cycle increment; halves are independent.
    wr(12'h320, 32'h60);
    wr(12'h324, 32'd7);
    step(1'b1, 12'hB04, 32'h100, 1'b0, 12'h0, 32'h0, 1'b0, ev7);
    rd(12'hB04, 32'h100, 1'b1);
    events(ev7, 1);
    rd(12'hB04, 32'h101, 1'b1);
    wr(12'hB84, 32'hDEAD);
    rd(12'hB84, 32'hDEAD, 1'b1);
    rd(12'hB04, 32'h101, 1'b1);
    step(1'b1, 12'hB04, 32'h200, 1'b1, 12'hB04, 32'h101, 1'b1, '0);
    rd(12'hB04, 32'h200, 1'b1);
    wr(12'h325, 32'h7FFFF03F);
    rd(12'h325, {1'b0, OVF, 30'h3F}, 1'b1);

    // Wrap and overflow on counter 3.
    wr(12'h323, 32'h40000005);
    rd(12'h323, {1'b0, OVF, 30'd5}, 1'b1);
    wr(12'hB03, 32'hFFFFFFFF);
    wr(12'hB83, 32'hFFFFFFFF);
    events(ev5, 1);
    chk("ovf_int_not_yet", 64'(hpm_ovf_int), 64'd0);
    @(posedge clk);
    #1;
    chk("ovf_int", 64'(hpm_ovf_int), 64'(OVF));
    rd(12'hB03, 32'd0, 1'b1);
    rd(12'hB83, 32'd0, 1'b1);
    rd(12'h323, {OVF, OVF, 30'd5}, 1'b1);

    // Hardware OF set wins over a same-cycle software clear.
    wr(12'h323, 32'h40000005);
    rd(12'h323, {1'b0, OVF, 30'd5}, 1'b1);
    chk("ovf_int_cleared", 64'(hpm_ovf_int), 64'd0);
    wr(12'hB03, 32'hFFFFFFFF);
    wr(12'hB83, 32'hFFFFFFFF);
    step(1'b1, 12'h323, 32'h40000005, 1'b0, 12'h0, 32'h0, 1'b0, ev5);
    rd(12'h323, {OVF, OVF, 30'd5}, 1'b1);
    rd(12'hB03, 32'd0, 1'b1);

    // Unmapped addresses.
    wr(12'h327, 32'hFFFFFFFF);
    wr(12'hB07, 32'h55);
    rd(12'hB1F, 32'h0, 1'b0);
    rd(12'hB07, 32'h0, 1'b0);
    rd(12'h327, 32'h0, 1'b0);
    rd(12'h323, {OVF, OVF, 30'd5}, 1'b1);

    // Reset with counting active and a read issued: the read is dropped.
    ev_in     = ev5;
    csr_ren   = 1'b1;
    csr_raddr = 12'hB03;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    csr_ren = 1'b0;
    ev_in   = '0;
    chk("rst2_rdata", 64'(csr_rdata), 64'd0);
    chk("rst2_rvalid", 64'(csr_rvalid), 64'd0);
    chk("rst2_rhit", 64'(csr_rhit), 64'd0);
    chk("rst2_int", 64'(hpm_ovf_int), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(12'h320, 32'h78, 1'b1);
    rd(12'hB03, 32'd0, 1'b1);
    rd(12'hB84, 32'd0, 1'b1);
    rd(12'h323, 32'd0, 1'b1);
    events(ev5, 4);
    rd(12'hB03, 32'd0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
